// File: rtl/ascon_byte_packer.sv
// Packs an 8-bit byte stream into 64-bit Ascon rate blocks with 10* padding
// (PAD_BYTE then zeros). A pad-only block follows any message whose length is a multiple of 8.
module ascon_byte_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h80,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] blk_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [63:0] word;
  logic        pad_pending;
  logic [63:0] word_ins;
  logic [63:0] word_pad;
  logic        accept;
  logic        handshake;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The sender holds valid and its payload stable until that edge; ready may change freely.
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign handshake = m_axis_tvalid && m_axis_tready;
  assign dbg_state = state;

  // Lane k occupies bits [63-8k -: 8]; word_pad also drops PAD_BYTE into the lane after the byte.
  always_comb begin
    word_ins = word;
    word_pad = word;
    for (int k = 0; k < 8; k++) begin
      if (idx == k[2:0]) begin
        word_ins[63-8*k -: 8] = s_axis_tdata;
      end
    end
    word_pad = word_ins;
    for (int k = 1; k < 8; k++) begin
      if (({1'b0, idx} + 4'd1) == k[3:0]) begin
        word_pad[63-8*k -: 8] = PAD_BYTE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state         <= ST_FILL;
      idx           <= 3'd0;
      word          <= 64'h0;
      pad_pending   <= 1'b0;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 64'h0;
      m_axis_tkeep  <= 4'd0;
      m_axis_tlast  <= 1'b0;
      blk_count     <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (s_axis_tlast && idx != 3'd7) begin
              m_axis_tdata  <= word_pad;
              m_axis_tkeep  <= {1'b0, idx} + 4'd1;
              m_axis_tlast  <= 1'b1;
              pad_pending   <= 1'b0;
              idx           <= 3'd0;
              word          <= 64'h0;
              s_axis_tready <= 1'b0;
              m_axis_tvalid <= 1'b1;
              state         <= ST_HOLD;
            end else if (idx == 3'd7) begin
              // A full last word leaves no room for the pad byte, so it gets its own block.
              m_axis_tdata  <= word_ins;
              m_axis_tkeep  <= 4'd8;
              m_axis_tlast  <= 1'b0;
              pad_pending   <= s_axis_tlast;
              idx           <= 3'd0;
              word          <= 64'h0;
              s_axis_tready <= 1'b0;
              m_axis_tvalid <= 1'b1;
              state         <= ST_HOLD;
            end else begin
              word <= word_ins;
              idx  <= idx + 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            blk_count <= blk_count + 1'b1;
            if (pad_pending) begin
              m_axis_tdata <= {PAD_BYTE, 56'h0};
              m_axis_tkeep <= 4'd0;
              m_axis_tlast <= 1'b1;
              state        <= ST_PAD;
            end else begin
              m_axis_tvalid <= 1'b0;
              s_axis_tready <= 1'b1;
              m_axis_tdata  <= 64'h0;
              m_axis_tkeep  <= 4'd0;
              m_axis_tlast  <= 1'b0;
              state         <= ST_FILL;
            end
          end
        end
        ST_PAD: begin
          if (handshake) begin
            blk_count     <= blk_count + 1'b1;
            pad_pending   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            m_axis_tdata  <= 64'h0;
            m_axis_tkeep  <= 4'd0;
            m_axis_tlast  <= 1'b0;
            state         <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_byte_packer.sv
// Directed bench for ascon_byte_packer: hand-computed blocks queued in a scoreboard.
module tb_ascon_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [15:0] blk_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  // {tlast, tkeep[3:0], tdata[63:0]}
  logic [68:0] exp_q[$];

  ascon_byte_packer #(.PAD_BYTE(8'h80), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .blk_count     (blk_count),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int budget;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    budget = 0;
    while (!s_axis_tready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!s_axis_tready) begin
      check("send_timeout", 64'd0, 64'd1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] first, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      send_byte(first + 8'(i), last && (i == n - 1));
    end
  endtask

  task automatic recv_block(input int stall);
    logic [68:0] e;
    int budget;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    @(negedge clk);
    budget = 0;
    while (!m_axis_tvalid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!m_axis_tvalid) begin
      check("recv_timeout", 64'd0, 64'd1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      check("stall_data", m_axis_tdata, e[63:0]);
      check("stall_valid", 64'(m_axis_tvalid), 64'd1);
      check("stall_s_tready", 64'(s_axis_tready), 64'd0);
      @(negedge clk);
    end
    check("blk_data", m_axis_tdata, e[63:0]);
    check("blk_keep", 64'(m_axis_tkeep), 64'(e[67:64]));
    check("blk_last", 64'(m_axis_tlast), 64'(e[68]));
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    exp_cnt++;
    check("blk_count", 64'(blk_count), 64'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_s_tready", 64'(s_axis_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_count", 64'(blk_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // Five bytes: partial block with pad; valid the cycle after the last accept.
    exp_q.push_back({1'b1, 4'd5, 64'h0102030405800000});
    send_seq(8'h01, 5, 1'b1);
    check("latency_valid", 64'(m_axis_tvalid), 64'd1);
    check("hold_state", 64'(dbg_state), 64'd1);
    recv_block(0);

    // Exactly eight bytes: full block then a pad-only block.
    exp_q.push_back({1'b0, 4'd8, 64'h0102030405060708});
    exp_q.push_back({1'b1, 4'd0, 64'h8000000000000000});
    send_seq(8'h01, 8, 1'b1);
    recv_block(0);
    check("pad_state", 64'(dbg_state), 64'd2);
    check("pad_s_tready", 64'(s_axis_tready), 64'd0);
    recv_block(0);
    #1;
    @(negedge clk);
    check("idle_s_tready", 64'(s_axis_tready), 64'd1);

    // Single byte message.
    exp_q.push_back({1'b1, 4'd1, 64'hAA80000000000000});
    send_byte(8'hAA, 1'b1);
    recv_block(0);

    // Twenty bytes with sink stalls.
    exp_q.push_back({1'b0, 4'd8, 64'h0001020304050607});
    exp_q.push_back({1'b0, 4'd8, 64'h08090A0B0C0D0E0F});
    exp_q.push_back({1'b1, 4'd4, 64'h1011121380000000});
    send_seq(8'h00, 8, 1'b0);
    recv_block(10);
    send_seq(8'h08, 8, 1'b0);
    recv_block(10);
    send_seq(8'h10, 4, 1'b1);
    recv_block(10);
    check("count_after_stall", 64'(blk_count), 64'd7);

    // Clear mid-word discards partial bytes and the count.
    send_seq(8'h11, 3, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_cnt = 0;
    check("clear_count", 64'(blk_count), 64'd0);
    check("clear_s_tready", 64'(s_axis_tready), 64'd1);
    exp_q.push_back({1'b1, 4'd2, 64'h5566800000000000});
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    recv_block(0);

    // Clear beats a same-cycle output handshake: block dropped, not counted.
    send_byte(8'h99, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_axis_tready = 1'b0;
    exp_cnt = 0;
    check("clrhs_valid", 64'(m_axis_tvalid), 64'd0);
    check("clrhs_count", 64'(blk_count), 64'd0);
    exp_q.push_back({1'b1, 4'd1, 64'h4280000000000000});
    send_byte(8'h42, 1'b1);
    recv_block(0);

    // Reset in hold alongside a sink handshake.
    send_byte(8'h77, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b0;
    exp_cnt = 0;
    check("rsthold_valid", 64'(m_axis_tvalid), 64'd0);
    check("rsthold_count", 64'(blk_count), 64'd0);
    check("rsthold_s_tready", 64'(s_axis_tready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
